// File: rtl/layer_output_packer.sv
// Serial-to-parallel packer: gathers NUM_NEURON beats into one flat vector and pulses o_data_valid.
// Optional macro PACKER_DROP_COUNT_EN builds a saturating counter of discarded beats.
module layer_output_packer #(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic                             i_clear,
  output logic [NUM_NEURON*DATA_WIDTH-1:0] o_data,
  output logic                             o_data_valid,
  output logic [7:0]                       o_drop_count
);

  localparam int CNT_W = ($clog2(NUM_NEURON) < 1) ? 1 : $clog2(NUM_NEURON);
  localparam int VEC_W = NUM_NEURON * DATA_WIDTH;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VEC_W-1:0]   shadow_q;
  logic [VEC_W-1:0]   shadow_d;
  logic [VEC_W-1:0]   data_q;
  logic               valid_q;
  logic               ready_q;
  logic               last_beat;

  assign last_beat = (cnt_q == CNT_W'(NUM_NEURON - 1));

  // Shadow with the current beat merged in, so the final beat can go straight to o_data.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_COLLECT;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          if (i_clear) begin
            cnt_q <= '0;
          end else if (i_valid && ready_q) begin
            shadow_q <= shadow_d;
            if (last_beat) begin
              state_q <= ST_EMIT;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              data_q  <= shadow_d;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          state_q <= ST_COLLECT;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_COLLECT;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;

`ifdef PACKER_DROP_COUNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_q <= 8'h00;
    end else if (i_valid && !ready_q && !i_clear && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign o_drop_count = drop_q;
`else
  assign o_drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_layer_output_packer.sv
// Bench for layer_output_packer: a queue-based reference for a 4x8 instance plus a default-parameter instance.
module tb_layer_output_packer;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    i_data = '0;
  logic            i_valid = 1'b0;
  logic            i_clear = 1'b0;
  logic            o_ready;
  logic [N*W-1:0]  o_data;
  logic            o_data_valid;
  logic [7:0]      o_drop_count;

  logic [15:0]     b_data = '0;
  logic            b_valid = 1'b0;
  logic            b_clear = 1'b0;
  logic            b_ready;
  logic [159:0]    b_dout;
  logic            b_dvalid;
  logic [7:0]      b_drop;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_output_packer #(.NUM_NEURON(N), .DATA_WIDTH(W)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_clear(i_clear), .o_data(o_data), .o_data_valid(o_data_valid), .o_drop_count(o_drop_count)
  );

  layer_output_packer u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .i_clear(b_clear), .o_data(b_dout), .o_data_valid(b_dvalid), .o_drop_count(b_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: beats gathered in a queue; a full queue becomes the next vector.
  logic [7:0]     elems[$];
  logic [N*W-1:0] m_data;
  bit             m_valid;
  bit             m_ready;
  int             m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elems.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ready = 1'b0;
      m_drop  = 0;
    end else begin
      if (i_valid && !m_ready && !i_clear && m_drop < 255) m_drop++;
      if (m_valid) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end else begin
        if (i_clear) begin
          elems.delete();
        end else if (i_valid && m_ready) begin
          elems.push_back(i_data);
          if (elems.size() == N) begin
            m_data = '0;
            foreach (elems[k]) m_data[k*W +: W] = elems[k];
            m_valid = 1'b1;
            elems.delete();
          end
        end
        m_ready = !m_valid;
      end
    end
  end

  function automatic int exp_drop(input int d);
`ifdef PACKER_DROP_COUNT_EN
    return d;
`else
    return 0;
`endif
  endfunction

  logic [N*W-1:0] got[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", o_ready, m_ready);
      chk("data_valid", o_data_valid, m_valid);
      chk("data", o_data, m_data);
      chk("drop_count", o_drop_count, exp_drop(m_drop));
      if (o_data_valid) got.push_back(o_data);
    end
  end

  task automatic send(input logic [7:0] q[$], input bit polite);
    int i = 0;
    int guard = 0;
    while (i < q.size() && guard < 200) begin
      @(negedge clk);
      guard++;
      i_data  = q[i];
      i_valid = (polite && !o_ready) ? 1'b0 : 1'b1;
      if (i_valid && o_ready) i++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d expected=%0d", i, q.size());
    end
  endtask

  int n0;
  int d0;
  logic [159:0] hold;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: basic vector, pulse in the cycle after the last beat with o_ready low
    send('{8'h11, 8'h22, 8'h33, 8'h44}, 1'b1);
    chk("t1_pulse_ready", {o_data_valid, o_ready}, 2'b10);
    chk("t1_model", m_data, 32'h44332211);
    repeat (2) @(negedge clk);
    chk("t1_count", got.size(), 1);
    chk("t1_data", got[0], 32'h44332211);

    // 2: continuous valid, EMIT beat held by source and retried
    n0 = got.size();
    send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_count", got.size(), n0 + 2);
    chk("t2_vec0", got[n0], 32'h04030201);
    chk("t2_vec1", got[n0+1], 32'h08070605);

    // 3: clear mid-vector with a concurrent beat
    n0 = got.size();
    d0 = o_drop_count;
    send('{8'h01, 8'h02}, 1'b1);
    i_clear = 1'b1; i_valid = 1'b1; i_data = 8'h99;
    @(negedge clk);
    i_clear = 1'b0; i_valid = 1'b0;
    send('{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_count", got.size(), n0 + 1);
    chk("t3_data", got[got.size()-1], 32'hDDCCBBAA);
    chk("t3_drop", o_drop_count, d0);

    // 4: source ignores o_ready for three vectors
    n0 = got.size();
    d0 = o_drop_count;
    for (int c = 0; c < 3*(N+1); c++) begin
      i_valid = 1'b1;
      i_data  = 8'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_count", got.size(), n0 + 3);
    chk("t4_drop", o_drop_count - 8'(d0), 8'(exp_drop(3)));

    // randomized traffic against the reference
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 9) < 6);
      i_clear = ($urandom_range(0, 19) == 0);
      i_data  = 8'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;

    // 5: reset mid-vector
    n0 = got.size();
    send('{8'h01, 8'h02, 8'h03}, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_no_pulse", got.size(), n0);
    chk("t5_rst_data", o_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_data_zero", o_data, 32'h0);
    send('{8'h05, 8'h06, 8'h07, 8'h08}, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_data", got[got.size()-1], 32'h08070605);

    // 6: default parameters, 10 x 16-bit elements
    for (int k = 0; k < 10; k++) begin
      b_valid = 1'b1;
      b_data  = 16'(k);
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("t6_pulse", b_dvalid, 1'b1);
    for (int k = 0; k < 10; k++) chk("t6_elem", b_dout[k*16 +: 16], 16'(k));
    hold = b_dout;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t6_pulse_low", b_dvalid, 1'b0);
      chk("t6_hold", b_dout, hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
